// File: rtl/turn_timer_pkg.sv
// Shared types and width helpers for the multi-player turn timer.
package turn_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        EXPIRED = 2'd2
    } turn_state_t;

    localparam int STATE_W = $bits(turn_state_t);

    // Counter width for n distinct values, never narrower than one bit.
    function automatic int min_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/second_prescaler.sv
// Divides the clock down to a one-cycle sec_tick every CLK_FREQ enabled cycles.
module second_prescaler
    import turn_timer_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic sec_tick
);

    localparam int                CNT_W = min_width(CLK_FREQ);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_FREQ - 1);

    logic [CNT_W-1:0] count;

    // A clear always wins, so a reload edge never doubles as a tick.
    assign sec_tick = enable && !clear && (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/turn_timer_multi.sv
// Multi-player turn timer: seconds countdown, low-time warning, player rotation.
// Define TURN_TIMER_AUTO_ADVANCE_EN to rotate players on expiry instead of parking in EXPIRED.
module turn_timer_multi
    import turn_timer_pkg::*;
#(
    parameter  int CLK_FREQ     = 50_000_000,
    parameter  int TURN_SECONDS = 10,
    parameter  int NUM_PLAYERS  = 2,
    parameter  int WARN_SECONDS = 3,
    localparam int SEC_W        = $clog2(TURN_SECONDS + 1),
    localparam int PLAYER_W     = $clog2(NUM_PLAYERS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                reset_timer,
    input  logic                turn_done,
    output logic                timeout,
    output logic                expired,
    output logic                warning,
    output logic [SEC_W-1:0]    seconds_left,
    output logic [PLAYER_W-1:0] current_player
);

    localparam logic [SEC_W-1:0]    SEC_FULL    = SEC_W'(TURN_SECONDS);
    localparam logic [PLAYER_W-1:0] LAST_PLAYER = PLAYER_W'(NUM_PLAYERS - 1);

    turn_state_t         state;
    logic                run_en;
    logic                advance;
    logic                presc_clear;
    logic                sec_tick;
    logic [PLAYER_W-1:0] next_player;

    function automatic logic warn_at(input logic [SEC_W-1:0] s);
        return (s <= SEC_W'(WARN_SECONDS)) && (s != '0);
    endfunction

    assign run_en      = (state == RUNNING) && enable;
    assign advance     = turn_done && (run_en || (state == EXPIRED));
    assign presc_clear = reset_timer || advance || (state != RUNNING);
    assign next_player = (current_player == LAST_PLAYER) ? '0 : current_player + 1'b1;

    second_prescaler #(
        .CLK_FREQ (CLK_FREQ)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .enable   (run_en),
        .clear    (presc_clear),
        .sec_tick (sec_tick)
    );

    // Branch order encodes event priority: reset_timer, then turn_done, then the tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            seconds_left   <= SEC_FULL;
            current_player <= '0;
            timeout        <= 1'b0;
            expired        <= 1'b0;
            warning        <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (reset_timer) begin
                seconds_left <= SEC_FULL;
                expired      <= 1'b0;
                state        <= enable ? RUNNING : IDLE;
                warning      <= enable && warn_at(SEC_FULL);
            end else if (advance) begin
                current_player <= next_player;
                seconds_left   <= SEC_FULL;
                expired        <= 1'b0;
                state          <= RUNNING;
                warning        <= warn_at(SEC_FULL);
            end else if (sec_tick) begin
                if (seconds_left == SEC_W'(1)) begin
                    timeout <= 1'b1;
`ifdef TURN_TIMER_AUTO_ADVANCE_EN
                    current_player <= next_player;
                    seconds_left   <= SEC_FULL;
                    warning        <= warn_at(SEC_FULL);
`else
                    seconds_left <= '0;
                    state        <= EXPIRED;
                    expired      <= 1'b1;
                    warning      <= 1'b0;
`endif
                end else begin
                    seconds_left <= seconds_left - 1'b1;
                    warning      <= warn_at(seconds_left - 1'b1);
                end
            end else if ((state == IDLE) && enable) begin
                state   <= RUNNING;
                warning <= warn_at(seconds_left);
            end
        end
    end

endmodule

// File: tb/tb_turn_timer_multi.sv
// Scoreboard bench for turn_timer_multi against an elapsed-cycle reference model.
module tb_turn_timer_multi;

    localparam int CLK_FREQ     = 10;
    localparam int TURN_SECONDS = 3;
    localparam int NUM_PLAYERS  = 3;
    localparam int WARN_SECONDS = 1;
    localparam int SEC_W        = $clog2(TURN_SECONDS + 1);
    localparam int PLAYER_W     = $clog2(NUM_PLAYERS);
`ifdef TURN_TIMER_AUTO_ADVANCE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic reset_timer = 1'b0;
    logic turn_done = 1'b0;
    logic                timeout;
    logic                expired;
    logic                warning;
    logic [SEC_W-1:0]    seconds_left;
    logic [PLAYER_W-1:0] current_player;

    turn_timer_multi #(
        .CLK_FREQ     (CLK_FREQ),
        .TURN_SECONDS (TURN_SECONDS),
        .NUM_PLAYERS  (NUM_PLAYERS),
        .WARN_SECONDS (WARN_SECONDS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .reset_timer    (reset_timer),
        .turn_done      (turn_done),
        .timeout        (timeout),
        .expired        (expired),
        .warning        (warning),
        .seconds_left   (seconds_left),
        .current_player (current_player)
    );

    always #5 clk = ~clk;

    typedef struct {
        int secs;
        int player;
        int tmo;
        int exp_lvl;
        int warn;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input int expv);
        n_checks++;
        if (act !== 32'(expv)) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
        end
    endtask

    // Reference model: a turn is TURN_SECONDS*CLK_FREQ enabled cycles; seconds are derived by division.
    initial begin : model
        bit   m_run;
        bit   m_exp;
        int   m_elapsed;
        int   m_player;
        bit   m_tmo;
        int   secs;
        exp_t e;
        m_run = 0; m_exp = 0; m_elapsed = 0; m_player = 0; m_tmo = 0;
        forever begin
            @(posedge clk);
            m_tmo = 0;
            if (rst) begin
                m_run = 0; m_exp = 0; m_elapsed = 0; m_player = 0;
            end else if (reset_timer) begin
                m_elapsed = 0; m_exp = 0; m_run = enable;
            end else if (turn_done && ((m_run && enable) || m_exp)) begin
                m_player  = (m_player + 1) % NUM_PLAYERS;
                m_elapsed = 0; m_run = 1; m_exp = 0;
            end else if (m_run && enable) begin
                m_elapsed++;
                if (m_elapsed == TURN_SECONDS * CLK_FREQ) begin
                    m_tmo = 1;
                    if (AUTO) begin
                        m_player  = (m_player + 1) % NUM_PLAYERS;
                        m_elapsed = 0;
                    end else begin
                        m_run = 0; m_exp = 1;
                    end
                end
            end else if (!m_run && !m_exp && enable) begin
                m_run = 1;
            end
            secs      = TURN_SECONDS - m_elapsed / CLK_FREQ;
            e.secs    = secs;
            e.player  = m_player;
            e.tmo     = m_tmo;
            e.exp_lvl = m_exp;
            e.warn    = (m_run && secs <= WARN_SECONDS && secs != 0) ? 1 : 0;
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty at %0t: got 0 entries, expected 1", $time);
            end else begin
                e = exp_q.pop_front();
                check("seconds_left",   32'(seconds_left),   e.secs);
                check("current_player", 32'(current_player), e.player);
                check("timeout",        32'(timeout),        e.tmo);
                check("expired",        32'(expired),        e.exp_lvl);
                check("warning",        32'(warning),        e.warn);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; reset_timer = 1'b0; turn_done = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic pulse_done();
        turn_done = 1'b1;
        step(1);
        turn_done = 1'b0;
    endtask

    initial begin : driver
        // Countdown, three consecutive expiries (or a long EXPIRED wait), then turn_done.
        do_reset();
        enable = 1'b1;
        step(100);
        pulse_done();
        step(10);

        // turn_done mid-turn.
        do_reset();
        enable = 1'b1;
        step(15);
        pulse_done();
        step(5);

        // turn_done coincident with the expiring tick.
        do_reset();
        enable = 1'b1;
        step(30);
        pulse_done();
        step(5);

        // Pause preserves the partial second.
        do_reset();
        enable = 1'b1;
        step(13);
        enable = 1'b0;
        step(25);
        enable = 1'b1;
        step(20);

        // reset_timer together with turn_done, then reset_timer while disabled.
        do_reset();
        enable = 1'b1;
        step(12);
        reset_timer = 1'b1; turn_done = 1'b1;
        step(1);
        reset_timer = 1'b0; turn_done = 1'b0;
        step(15);
        enable = 1'b0; reset_timer = 1'b1;
        step(1);
        reset_timer = 1'b0;
        step(3);
        enable = 1'b1;
        step(5);

        // Randomised traffic including mid-turn resets.
        repeat (1500) begin
            enable      = ($urandom_range(0, 9) != 0);
            turn_done   = ($urandom_range(0, 39) == 0);
            reset_timer = ($urandom_range(0, 59) == 0);
            rst         = ($urandom_range(0, 199) == 0);
            step(1);
        end
        rst = 1'b0; enable = 1'b0; turn_done = 1'b0; reset_timer = 1'b0;
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/turn_timer_multi.md
# turn_timer_multi

Parametrised multi-player turn timer for the game datapath. It generalises the single-player turn timer with these additions:
- configurable turn length and player count;
- down-counting seconds display;
- low-time warning;
- explicit end-of-turn input that rotates the active player.

It sits between the game FSM (which issues `enable`, `reset_timer`, `turn_done`) and the display/score logic (which consume `seconds_left`, `current_player`, `timeout`).

## Interface
- `CLK_FREQ`, 50_000_000: clock cycles per second; prescaler terminal count is `CLK_FREQ-1`.
- `TURN_SECONDS`, 10: turn length in seconds; legal range ≥1.
- `NUM_PLAYERS`, 2: number of players; legal range ≥2.
- `WARN_SECONDS`, 3: `warning` asserts when `seconds_left` ≤ this value; legal range < `TURN_SECONDS`.
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: run when high; freeze all counters when low.
- `reset_timer` input 1: reload the current turn; the player is unchanged.
- `turn_done` input 1: single-cycle pulse; the current player has moved, so advance the turn.
- `timeout` output 1: single-cycle pulse when the turn expires.
- `expired` output 1: level; high while waiting in EXPIRED.
- `warning` output 1: level; low time remaining.
- `seconds_left` output SEC_W: seconds remaining, where SEC_W = $clog2(TURN_SECONDS+1).
- `current_player` output PLAYER_W: active player, where PLAYER_W = $clog2(NUM_PLAYERS).

## Operation
- States are IDLE, RUNNING and EXPIRED.
- Reset values:
  - state IDLE, prescaler 0;
  - `seconds_left`=TURN_SECONDS, `current_player`=0;
  - `timeout`=0, `expired`=0, `warning`=0.
- IDLE: when `enable`=1, go to RUNNING on the next edge. The prescaler starts from 0.
- RUNNING with `enable`=1:
  - The prescaler increments every cycle.
  - When it reaches `CLK_FREQ-1` it wraps to 0 and raises the internal `sec_tick`.
  - On each `sec_tick`, `seconds_left` decrements.
- RUNNING with `enable`=0: prescaler, `seconds_left` and state all hold. `turn_done` and ticks are ignored.
- Expiry is a `sec_tick` while `seconds_left`==1. It produces `timeout`=1 for exactly one cycle, registered on that edge. The rest depends on the Configuration macro.
- `turn_done` (honoured in RUNNING with `enable`=1, and in EXPIRED):
  - `current_player` advances by 1, wrapping from NUM_PLAYERS-1 to 0;
  - `seconds_left` reloads to TURN_SECONDS and the prescaler resets to 0;
  - state goes to RUNNING and `expired` clears.
- `reset_timer`:
  - reloads `seconds_left` and the prescaler and clears `expired`;
  - leaves `current_player` unchanged;
  - next state is RUNNING if `enable`=1, otherwise IDLE.
- `warning` = (state==RUNNING) && (`seconds_left` ≤ WARN_SECONDS) && (`seconds_left` != 0). It is registered.
- Priority when events coincide: `rst` > `reset_timer` > `turn_done` > `sec_tick`.
  - `turn_done` coincident with the expiring tick: no `timeout`, normal advance.
  - `reset_timer` coincident with `turn_done`: reload only, no player advance.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- `turn_done` and `reset_timer` take effect on the first rising edge they are sampled. Outputs update in the same cycle that edge produces.
- Turn duration from entering RUNNING to the `timeout` pulse is exactly TURN_SECONDS×CLK_FREQ enabled cycles. Cycles with `enable` low are excluded.
- A partial second is preserved across `enable` low periods: the prescaler is not cleared.
- `rst` mid-turn returns every output to its reset value on the next edge.

## Configuration
- Macro: `TURN_TIMER_AUTO_ADVANCE_EN`.
- When defined, on the expiry edge:
  - `timeout` pulses;
  - `current_player` advances with wrap;
  - `seconds_left` reloads to TURN_SECONDS and the prescaler goes to 0;
  - state stays RUNNING and `expired` never asserts.
- When undefined, on the expiry edge:
  - `timeout` pulses and `seconds_left`=0;
  - state goes to EXPIRED and `expired`=1;
  - `current_player` is unchanged.
  - It waits in EXPIRED, ignoring `enable`, until `turn_done` or `reset_timer`.

## Structure
- Package `turn_timer_pkg`: state enum `turn_state_t` (IDLE, RUNNING, EXPIRED) and width helper constants.
- Sub-module `second_prescaler`:
  - parameter CLK_FREQ;
  - inputs `clk`, `rst`, `enable`, `clear`;
  - output `sec_tick`.
  - It contains the cycle counter; the top level contains the FSM, seconds counter and player counter.

## Test plan
Bench parameters are CLK_FREQ=10, TURN_SECONDS=3, NUM_PLAYERS=3, WARN_SECONDS=1, and the macro is defined unless noted.
- Reset: hold `rst` for 2 cycles, then check `seconds_left`=3, `current_player`=0, `timeout`=`expired`=`warning`=0.
- Countdown: with `enable`=1 from cycle 0:
  - `seconds_left` goes 3→2 at cycle 10 and 2→1 at cycle 20, when `warning` rises;
  - at cycle 30, `timeout` pulses for 1 cycle, `current_player`=1, `seconds_left`=3.
- Wrap: let 3 consecutive timeouts occur; `current_player` sequence is 1, 2, 0.
- `turn_done` at cycle 15:
  - next cycle `current_player`=1, `seconds_left`=3, no `timeout`;
  - repeated with `turn_done` coincident with the expiring tick: no `timeout` pulse, player advances once.
- Pause: drop `enable` at cycle 13 for 25 cycles; `seconds_left` stays at 2, then the 2→1 transition occurs 7 enabled cycles after resume.
- Macro undefined:
  - at cycle 30, `timeout` pulses, `expired`=1, `seconds_left`=0, `current_player`=0, and this holds for 50 cycles;
  - `turn_done` then gives `expired`=0, `current_player`=1, `seconds_left`=3.
